// File: rtl/rvfi_bus_dmem_monitor.sv
// Passive in-order bus monitor: queues accepted requests and, on each response
// handshake, emits one registered RVFI_BUS record pairing the request with its response.
module rvfi_bus_dmem_monitor #(
    parameter int XLEN   = 32,
    parameter int BUSLEN = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic                       req_ready,
    input  logic                       req_data,
    input  logic [XLEN-1:0]            req_addr,
    input  logic [BUSLEN/8-1:0]        req_rmask,
    input  logic [BUSLEN/8-1:0]        req_wmask,
    input  logic [BUSLEN-1:0]          req_wdata,
    input  logic                       rsp_valid,
    input  logic                       rsp_ready,
    input  logic [BUSLEN-1:0]          rsp_rdata,
    input  logic                       rsp_fault,
    output logic                       rvfi_bus_valid,
    output logic                       rvfi_bus_insn,
    output logic                       rvfi_bus_data,
    output logic                       rvfi_bus_fault,
    output logic [XLEN-1:0]            rvfi_bus_addr,
    output logic [BUSLEN/8-1:0]        rvfi_bus_rmask,
    output logic [BUSLEN/8-1:0]        rvfi_bus_wmask,
    output logic [BUSLEN-1:0]          rvfi_bus_rdata,
    output logic [BUSLEN-1:0]          rvfi_bus_wdata,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       err_overflow,
    output logic                       err_orphan
);
    localparam int MW = BUSLEN / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   addr_mem  [DEPTH];
    logic [MW-1:0]     rmask_mem [DEPTH];
    logic [MW-1:0]     wmask_mem [DEPTH];
    logic [BUSLEN-1:0] wdata_mem [DEPTH];
    logic              data_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] pending_reg, pending_next;
    logic          overflow_reg, overflow_next;
    logic          orphan_reg, orphan_next;

    logic              valid_reg, insn_reg, data_reg, fault_reg;
    logic [XLEN-1:0]   addr_reg;
    logic [MW-1:0]     rmask_reg, wmask_reg;
    logic [BUSLEN-1:0] rdata_reg, wdata_reg;

    logic req_fire, rsp_fire, fifo_full, fifo_empty, push_ok, pop_ok;

    assign req_fire   = req_valid && req_ready;
    assign rsp_fire   = rsp_valid && rsp_ready;
    assign fifo_full  = (pending_reg == PW'(DEPTH));
    assign fifo_empty = (pending_reg == '0);
    assign pop_ok     = rsp_fire && !fifo_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = req_fire && (!fifo_full || pop_ok);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        pending_next  = pending_reg;
        overflow_next = overflow_reg || (req_fire && !push_ok);
        orphan_next   = orphan_reg || (rsp_fire && fifo_empty);
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            pending_next = pending_reg + PW'(1);
        end else if (pop_ok && !push_ok) begin
            pending_next = pending_reg - PW'(1);
        end
    end

    // Payload storage carries no reset: occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            addr_mem[wr_ptr_reg]  <= req_addr;
            rmask_mem[wr_ptr_reg] <= req_rmask;
            wmask_mem[wr_ptr_reg] <= req_wmask;
            wdata_mem[wr_ptr_reg] <= req_wdata;
            data_mem[wr_ptr_reg]  <= req_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
            orphan_reg   <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            orphan_reg   <= orphan_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            insn_reg  <= 1'b0;
            data_reg  <= 1'b0;
            fault_reg <= 1'b0;
            addr_reg  <= '0;
            rmask_reg <= '0;
            wmask_reg <= '0;
            rdata_reg <= '0;
            wdata_reg <= '0;
        end else begin
            valid_reg <= pop_ok;
            if (pop_ok) begin
                insn_reg  <= !data_mem[rd_ptr_reg];
                data_reg  <= data_mem[rd_ptr_reg];
                fault_reg <= rsp_fault;
                addr_reg  <= addr_mem[rd_ptr_reg];
                rmask_reg <= rmask_mem[rd_ptr_reg];
                wmask_reg <= wmask_mem[rd_ptr_reg];
                rdata_reg <= rsp_rdata;
                wdata_reg <= wdata_mem[rd_ptr_reg];
            end
        end
    end

    assign rvfi_bus_valid = valid_reg;
    assign rvfi_bus_insn  = insn_reg;
    assign rvfi_bus_data  = data_reg;
    assign rvfi_bus_fault = fault_reg;
    assign rvfi_bus_addr  = addr_reg;
    assign rvfi_bus_rmask = rmask_reg;
    assign rvfi_bus_wmask = wmask_reg;
    assign rvfi_bus_rdata = rdata_reg;
    assign rvfi_bus_wdata = wdata_reg;
    assign pending        = pending_reg;
    assign err_overflow   = overflow_reg;
    assign err_orphan     = orphan_reg;

endmodule

// File: tb/tb_rvfi_bus_dmem_monitor.sv
// Bench for rvfi_bus_dmem_monitor: hand-written cycle table, async reset sequence,
// then random traffic against a queue-based reference model.
module tb_rvfi_bus_dmem_monitor;
    localparam int DEPTH = 4;

    logic        clock, reset;
    logic        req_valid, req_ready, req_data;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_rmask, req_wmask;
    logic        rsp_valid, rsp_ready, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault;
    logic [31:0] rvfi_bus_addr, rvfi_bus_rdata, rvfi_bus_wdata;
    logic [3:0]  rvfi_bus_rmask, rvfi_bus_wmask;
    logic [2:0]  pending;
    logic        err_overflow, err_orphan;

    rvfi_bus_dmem_monitor #(.XLEN(32), .BUSLEN(32), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_addr(req_addr), .req_rmask(req_rmask), .req_wmask(req_wmask),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault),
        .rvfi_bus_valid(rvfi_bus_valid), .rvfi_bus_insn(rvfi_bus_insn),
        .rvfi_bus_data(rvfi_bus_data), .rvfi_bus_fault(rvfi_bus_fault),
        .rvfi_bus_addr(rvfi_bus_addr), .rvfi_bus_rmask(rvfi_bus_rmask),
        .rvfi_bus_wmask(rvfi_bus_wmask), .rvfi_bus_rdata(rvfi_bus_rdata),
        .rvfi_bus_wdata(rvfi_bus_wdata), .pending(pending),
        .err_overflow(err_overflow), .err_orphan(err_orphan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rm, wm;
        logic [31:0] wd;
        logic        d;
    } req_t;

    req_t        mq[$];
    logic        m_valid, m_insn, m_data, m_fault, m_ovf, m_orph;
    logic [31:0] m_addr, m_rdata, m_wdata;
    logic [3:0]  m_rmask, m_wmask;

    task automatic model_reset();
        mq.delete();
        m_valid = 0; m_insn = 0; m_data = 0; m_fault = 0; m_ovf = 0; m_orph = 0;
        m_addr = 0; m_rdata = 0; m_wdata = 0; m_rmask = 0; m_wmask = 0;
    endtask

    // Responses retire the oldest request first; a request fits if room remains afterwards.
    task automatic model_update();
        req_t e;
        m_valid = 0;
        if (rsp_valid && rsp_ready) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_valid = 1; m_addr = e.addr; m_rmask = e.rm; m_wmask = e.wm;
                m_wdata = e.wd; m_data = e.d; m_insn = !e.d;
                m_rdata = rsp_rdata; m_fault = rsp_fault;
            end else begin
                m_orph = 1;
            end
        end
        if (req_valid && req_ready) begin
            if (mq.size() < DEPTH) begin
                e.addr = req_addr; e.rm = req_rmask; e.wm = req_wmask;
                e.wd = req_wdata; e.d = req_data;
                mq.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic compare_model();
        chk("valid", 64'(rvfi_bus_valid), 64'(m_valid));
        chk("pending", 64'(pending), 64'(mq.size()));
        chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
        chk("err_orphan", 64'(err_orphan), 64'(m_orph));
        chk("addr", 64'(rvfi_bus_addr), 64'(m_addr));
        chk("rmask", 64'(rvfi_bus_rmask), 64'(m_rmask));
        chk("wmask", 64'(rvfi_bus_wmask), 64'(m_wmask));
        chk("wdata", 64'(rvfi_bus_wdata), 64'(m_wdata));
        chk("rdata", 64'(rvfi_bus_rdata), 64'(m_rdata));
        chk("data", 64'(rvfi_bus_data), 64'(m_data));
        chk("insn", 64'(rvfi_bus_insn), 64'(m_insn));
        chk("fault", 64'(rvfi_bus_fault), 64'(m_fault));
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic drive(input logic rqv, input logic rqr, input logic rqd, input logic [31:0] a,
                         input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                         input logic rsv, input logic rsr, input logic [31:0] rd, input logic f);
        req_valid = rqv; req_ready = rqr; req_data = rqd; req_addr = a;
        req_rmask = rm; req_wmask = wm; req_wdata = wd;
        rsp_valid = rsv; rsp_ready = rsr; rsp_rdata = rd; rsp_fault = f;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic rqv, rqr, rqd; logic [31:0] a; logic [3:0] rm, wm; logic [31:0] wd;
        logic rsv, rsr; logic [31:0] rd; logic f;
        logic ev; int ep; logic eov, eor;
        logic [31:0] ea; logic [3:0] erm, ewm; logic [31:0] ewd, erd; logic ed, ef;
    } vec_t;

    function automatic vec_t mk(input logic rqv, input logic rqr, input logic rqd, input logic [31:0] a,
                                input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                                input logic rsv, input logic rsr, input logic [31:0] rd, input logic f,
                                input logic ev, input int ep, input logic eov, input logic eor,
                                input logic [31:0] ea, input logic [3:0] erm, input logic [3:0] ewm,
                                input logic [31:0] ewd, input logic [31:0] erd, input logic ed, input logic ef);
        vec_t v;
        v.rqv = rqv; v.rqr = rqr; v.rqd = rqd; v.a = a; v.rm = rm; v.wm = wm; v.wd = wd;
        v.rsv = rsv; v.rsr = rsr; v.rd = rd; v.f = f;
        v.ev = ev; v.ep = ep; v.eov = eov; v.eor = eor; v.ea = ea; v.erm = erm; v.ewm = ewm;
        v.ewd = ewd; v.erd = erd; v.ed = ed; v.ef = ef;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // single read
        tbl.push_back(mk(1,1,1,32'h100,4'hF,4'h0,0, 0,0,0,0, 0,1,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hDEADBEEF,0, 1,0,0,0, 32'h100,4'hF,4'h0,0,32'hDEADBEEF,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        // faulting write
        tbl.push_back(mk(1,1,1,32'h204,4'h0,4'h3,32'h1234, 0,0,0,0, 0,1,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'h0,1, 1,0,0,0, 32'h204,4'h0,4'h3,32'h1234,32'h0,1,1));
        // ordering and pointer wrap; the 0x10 push lands on a full FIFO with a pop
        tbl.push_back(mk(1,1,1,32'h0,4'hF,4'h0,0, 0,0,0,0, 0,1,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,32'h4,4'hF,4'h0,0, 0,0,0,0, 0,2,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h8,4'hF,4'h0,0, 0,0,0,0, 0,3,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'hC,4'hF,4'h0,0, 0,0,0,0, 0,4,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h10,4'hF,4'h0,0, 1,1,32'hA0,0, 1,4,0,0, 32'h0,4'hF,4'h0,0,32'hA0,1,0));
        tbl.push_back(mk(1,1,1,32'h14,4'hF,4'h0,0, 1,1,32'hA1,0, 1,4,0,0, 32'h4,4'hF,4'h0,0,32'hA1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hA2,0, 1,3,0,0, 32'h8,4'hF,4'h0,0,32'hA2,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hA3,0, 1,2,0,0, 32'hC,4'hF,4'h0,0,32'hA3,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hA4,0, 1,1,0,0, 32'h10,4'hF,4'h0,0,32'hA4,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hA5,0, 1,0,0,0, 32'h14,4'hF,4'h0,0,32'hA5,1,0));
        // full boundary: push+pop at full is fine, lone push at full overflows
        tbl.push_back(mk(1,1,1,32'h40,4'h0,4'hF,32'h40, 0,0,0,0, 0,1,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h44,4'h0,4'hF,32'h44, 0,0,0,0, 0,2,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h48,4'h0,4'hF,32'h48, 0,0,0,0, 0,3,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h4C,4'h0,4'hF,32'h4C, 0,0,0,0, 0,4,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h50,4'h0,4'hF,32'h50, 1,1,32'hB0,0, 1,4,0,0, 32'h40,4'h0,4'hF,32'h40,32'hB0,1,0));
        tbl.push_back(mk(1,1,1,32'h99,4'h0,4'hF,32'h99, 0,0,0,0, 0,4,1,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hB1,0, 1,3,1,0, 32'h44,4'h0,4'hF,32'h44,32'hB1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hB2,0, 1,2,1,0, 32'h48,4'h0,4'hF,32'h48,32'hB2,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hB3,0, 1,1,1,0, 32'h4C,4'h0,4'hF,32'h4C,32'hB3,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hB4,0, 1,0,1,0, 32'h50,4'h0,4'hF,32'h50,32'hB4,1,0));
        // orphan with same-cycle push of an entry carrying no masks
        tbl.push_back(mk(1,1,1,32'h60,4'h0,4'h0,32'h5, 1,1,32'hC9,0, 0,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,32'hC0,0, 1,0,1,1, 32'h60,4'h0,4'h0,32'h5,32'hC0,1,0));
        // handshakes need both valid and ready
        tbl.push_back(mk(1,1,1,32'h70,4'h3,4'h0,0, 0,0,0,0, 0,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,0,32'hD9,0, 0,1,1,1, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,32'h77,4'hF,4'h0,0, 1,1,32'hD0,0, 1,0,1,1, 32'h70,4'h3,4'h0,0,32'hD0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,1,1, 0,0,0,0,0,0,0));
    end

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0;
        drive(0,0,0,0,0,0,0, 0,0,0,0);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_model();
        #3 reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rqv, tbl[i].rqr, tbl[i].rqd, tbl[i].a, tbl[i].rm, tbl[i].wm, tbl[i].wd,
                  tbl[i].rsv, tbl[i].rsr, tbl[i].rd, tbl[i].f);
            step();
            chk("tbl_valid", 64'(rvfi_bus_valid), 64'(tbl[i].ev));
            chk("tbl_pending", 64'(pending), 64'(tbl[i].ep));
            chk("tbl_overflow", 64'(err_overflow), 64'(tbl[i].eov));
            chk("tbl_orphan", 64'(err_orphan), 64'(tbl[i].eor));
            if (tbl[i].ev) begin
                chk("tbl_addr", 64'(rvfi_bus_addr), 64'(tbl[i].ea));
                chk("tbl_rmask", 64'(rvfi_bus_rmask), 64'(tbl[i].erm));
                chk("tbl_wmask", 64'(rvfi_bus_wmask), 64'(tbl[i].ewm));
                chk("tbl_wdata", 64'(rvfi_bus_wdata), 64'(tbl[i].ewd));
                chk("tbl_rdata", 64'(rvfi_bus_rdata), 64'(tbl[i].erd));
                chk("tbl_data", 64'(rvfi_bus_data), 64'(tbl[i].ed));
                chk("tbl_insn", 64'(rvfi_bus_insn), 64'(!tbl[i].ed));
                chk("tbl_fault", 64'(rvfi_bus_fault), 64'(tbl[i].ef));
            end
            $display("row %0d: valid=%0d addr=0x%0h rdata=0x%0h pending=%0d ovf=%0d orph=%0d",
                     i, rvfi_bus_valid, rvfi_bus_addr, rvfi_bus_rdata, pending, err_overflow, err_orphan);
        end

        // async reset with three requests in flight
        for (int i = 0; i < 3; i++) begin
            drive(1,1,1,32'h300 + 32'(i*4),4'hF,4'h0,32'h0, (i == 2),(i == 2),32'hE0,1);
            step();
        end
        drive(1,1,1,32'h310,4'hF,4'h0,0, 0,0,0,0);
        step();
        chk("pre_reset_pending", 64'(pending), 64'd3);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_model();
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_addr", 64'(rvfi_bus_addr), 64'd0);
        drive(0,0,0,0,0,0,0, 1,1,32'hF0,0);
        #3 reset = 1'b1;
        step();
        chk("post_reset_orphan", 64'(err_orphan), 64'd1);
        chk("post_reset_valid", 64'(rvfi_bus_valid), 64'd0);
        $display("reset seq: pending=%0d orph=%0d valid=%0d", pending, err_orphan, rvfi_bus_valid);

        // random traffic alternating between filling and draining bias
        for (int c = 0; c < 2000; c++) begin
            int rq_pct, rs_pct;
            rq_pct = ((c / 150) % 2 == 0) ? 75 : 30;
            rs_pct = ((c / 150) % 2 == 0) ? 30 : 75;
            drive(($urandom_range(0,99) < rq_pct), ($urandom_range(0,9) != 0), 1'($urandom),
                  $urandom, 4'($urandom), 4'($urandom), $urandom,
                  ($urandom_range(0,99) < rs_pct), ($urandom_range(0,9) != 0), $urandom,
                  ($urandom_range(0,7) == 0));
            step();
            if (rvfi_bus_valid)
                $display("rand %0d: addr=0x%0h rdata=0x%0h fault=%0d pending=%0d",
                         c, rvfi_bus_addr, rvfi_bus_rdata, rvfi_bus_fault, pending);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rvfi_bus_dmem_monitor.md
# rvfi_bus_dmem_monitor

Passive monitor that observes one in-order request/response memory bus between the core (or its cache) and memory. It produces the single-channel `RVFI_BUS` record stream consumed by the bus checks. Each accepted request is queued in a pending FIFO. When the matching response handshake occurs, the block emits one registered `rvfi_bus_*` record that combines the request's address, masks and write data with the response's read data and fault flag. It never drives the observed bus.

## Interface
- `XLEN`, 32, address width (matches `RISCV_FORMAL_XLEN`)
- `BUSLEN`, 32, bus data width in bits (matches `RISCV_FORMAL_BUSLEN`), multiple of 8
- `DEPTH`, 4, maximum outstanding requests, power of two, ≥2
- `clock`  input  1  single clock, all state on rising edge
- `reset`  input  1  reset, asynchronous and active-low (low = in reset)
- `req_valid`, `req_ready`  input  1  observed request handshake
- `req_data`  input  1  1 = data access, 0 = instruction fetch
- `req_addr`  input  XLEN  request byte address
- `req_rmask`, `req_wmask`  input  BUSLEN/8  byte read/write masks
- `req_wdata`  input  BUSLEN  write data
- `rsp_valid`, `rsp_ready`  input  1  observed response handshake
- `rsp_rdata`  input  BUSLEN  read data
- `rsp_fault`  input  1  bus error for this response
- `rvfi_bus_valid`, `rvfi_bus_insn`, `rvfi_bus_data`, `rvfi_bus_fault`  output  1  record fields
- `rvfi_bus_addr`  output  XLEN
- `rvfi_bus_rmask`, `rvfi_bus_wmask`  output  BUSLEN/8
- `rvfi_bus_rdata`, `rvfi_bus_wdata`  output  BUSLEN
- `pending`  output  $clog2(DEPTH+1)  current FIFO occupancy
- `err_overflow`  output  1  sticky: request accepted while FIFO full
- `err_orphan`  output  1  sticky: response with no pending request

## Operation
- Push: `req_valid && req_ready` pushes {addr, rmask, wmask, wdata, data} into the FIFO. The write pointer wraps modulo DEPTH.
- Pop: `rsp_valid && rsp_ready` with `pending != 0` pops the head and loads the output record:
  - `addr`, `rmask`, `wmask`, `wdata` come from the head entry.
  - `data` comes from the head entry; `insn` = !head.data.
  - `rdata` = `rsp_rdata`; `fault` = `rsp_fault`.
  - `rvfi_bus_valid` = 1.
- Cycles with no pop: `rvfi_bus_valid` = 0. The other record fields hold their last value.
- Occupancy arithmetic: `pending` next = pending + push − pop, where pop applies only when `pending != 0`.
- FIFO full (`pending == DEPTH`):
  - Push without pop: entry dropped, pointers unchanged, `err_overflow` set.
  - Push with same-cycle pop: both occur; pending stays DEPTH. Not an error.
- FIFO empty:
  - A response handshake sets `err_orphan`, emits no record and leaves pointers unchanged.
  - A same-cycle request still pushes. A response can never complete a request accepted in the same cycle (minimum latency 1).
- Error flags are sticky until reset. They do not stop monitoring.
- Masks are copied unmodified. Entries with both masks zero are still tracked and emitted.

## Timing
- Reset asserted (low): asynchronously clears pointers, `pending`, `err_*`, `rvfi_bus_valid` and all record fields to 0.
- Reset released: first push/pop is sampled on the first rising edge with `reset` high.
- Reset mid-operation discards all pending entries. Responses arriving after release with an empty FIFO count as orphans.
- Latency: a response handshake in cycle N produces `rvfi_bus_valid` = 1 in cycle N+1, held for exactly one cycle per response.
- Back-to-back responses in N and N+1 produce valid records in N+1 and N+2, with no gap.
- `pending` and `err_*` are registered and update in the cycle after the causing handshake.
- No combinational path from any input to any output.

## Test plan
- Single read: push addr 0x100, rmask 0xF, data=1; two cycles later respond rdata 0xDEADBEEF, fault 0. Required: one-cycle record with addr 0x100, rmask 0xF, wmask 0, rdata 0xDEADBEEF, data=1, insn=0, fault=0; `pending` returns 1→0.
- Faulting write: push addr 0x204, wmask 0x3, wdata 0x1234; respond with fault 1. Required: record fault=1, wmask 0x3, wdata 0x1234.
- Ordering/wrap: push 6 requests with addr 0x0, 0x4, …, 0x14 (DEPTH=4, interleaved with responses so occupancy never exceeds 4). Required: records in issue order with matching addresses, no errors.
- Full boundary:
  - Fill to 4, then push and pop in the same cycle. Required: pending stays 4, `err_overflow`=0.
  - Then push alone. Required: `err_overflow`=1, pending 4, dropped entry never emitted.
- Orphan: response on an empty FIFO. Required: no record, `err_orphan`=1. A same-cycle request is still pushed (pending=1).
- Async reset: with 3 pending, pulse `reset` low mid-cycle. Required: outputs and pending go to 0 immediately, and the next response sets `err_orphan`.
